// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential restoring divider. Produces the unsigned quotient and
//             remainder of two WIDTH-bit operands, one quotient bit per clock,
//             behind a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    // Partial remainder. After each restoring step it is strictly below the
    // divisor, so WIDTH bits suffice; the extra bit only exists transiently in
    // the shifted value below.
    logic [WIDTH-1:0]   part_rem;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   div_reg;

    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               fits;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   q_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The difference is exact modulo 2^WIDTH because it is only used when the
    // true result is below the divisor.
    always_comb begin
        shifted  = {part_rem, shift_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, div_reg});
        diff     = shifted[WIDTH-1:0] - div_reg;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        q_next   = {shift_q[WIDTH-2:0], fits};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            part_rem    <= '0;
            shift_q     <= '0;
            div_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                            count    <= CNT_W'(WIDTH - 1);
                            part_rem <= '0;
                            shift_q  <= dividend;
                            div_reg  <= divisor;
                        end else begin
                            // Divide by zero resolves immediately without RUN.
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    part_rem <= rem_next;
                    shift_q  <= q_next;
                    if (count == '0) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (WIDTH=4) using a plain
//             arithmetic reference model, directed and random operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Results the DUT is expected to be presenting right now.
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic ref_div(input int a, input int b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        if (b == 0) begin
            q = '1; r = W'(a); z = 1'b1;
        end else begin
            q = W'(a / b); r = W'(a % b); z = 1'b0;
        end
    endtask

    // One operation observed over a fixed window after the start edge.
    // inject_k > 0 pulses a competing start during that RUN cycle.
    task automatic run_op(input int a, input int b, input int inject_k);
        logic [W-1:0] eq, er;
        logic         ez;
        int           busy_cnt, done_at, done_cnt;
        logic         stable;
        string        tag;
        tag = $sformatf("%0d/%0d", a, b);
        ref_div(a, b, eq, er, ez);
        @(negedge clk);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        busy_cnt = 0; done_at = 0; done_cnt = 0; stable = 1'b1;
        for (int k = 1; k <= W + 3; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (done_at == 0) begin
                if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z) stable = 1'b0;
            end else begin
                if (quotient !== eq || remainder !== er || div_by_zero !== ez) stable = 1'b0;
            end
            if (inject_k != 0 && k == inject_k) begin
                start = 1'b1; dividend = 4'd9; divisor = 4'd2;
            end
            if (inject_k != 0 && k == inject_k + 1) start = 1'b0;
            if (k < W + 3) begin
                @(posedge clk); #1;
            end
        end
        check({tag, " done_cycle"}, done_at, (b == 0) ? 1 : W + 1);
        check({tag, " busy_cycles"}, busy_cnt, (b == 0) ? 0 : W);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, ez);
        check({tag, " outputs_stable"}, stable, 1);
        last_q = eq; last_r = er; last_z = ez;
    endtask

    initial begin
        int           cyc;
        int           done_seen;
        int           a1, b1, a2, b2;
        logic [W-1:0] eq, er;
        logic         ez;

        // Reset held low for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases.
        run_op(13, 3, 0);
        run_op(7, 0, 0);
        run_op(15, 1, 0);
        run_op(2, 9, 0);
        run_op(15, 15, 0);
        run_op(0, 5, 0);

        // Start during RUN is ignored.
        run_op(12, 5, 2);

        // Asynchronous reset during RUN discards the operation.
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("midrun_reset busy", busy, 0);
        check("midrun_reset done", done, 0);
        check("midrun_reset quotient", quotient, 0);
        check("midrun_reset remainder", remainder, 0);
        check("midrun_reset div_by_zero", div_by_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 2 * W + 2; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrun_reset no_activity", done_seen, 0);
        last_q = '0; last_r = '0; last_z = 1'b0;
        run_op(14, 3, 0);

        // Back-to-back: start held high through done.
        a1 = 11; b1 = 2;
        a2 = int'($urandom_range(0, 15));
        b2 = int'($urandom_range(1, 15));
        @(negedge clk);
        start = 1'b1; dividend = W'(a1); divisor = W'(b1);
        @(posedge clk); #1;
        dividend = W'(a2); divisor = W'(b2);
        cyc = 1;
        while (!done && cyc <= 3 * W) begin
            @(posedge clk); #1;
            cyc++;
        end
        ref_div(a1, b1, eq, er, ez);
        check("b2b first done_cycle", cyc, W + 1);
        check("b2b first quotient", quotient, eq);
        check("b2b first remainder", remainder, er);
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        check("b2b second busy", busy, 1);
        check("b2b first held_quotient", quotient, eq);
        cyc = 1;
        while (!done && cyc <= 3 * W) begin
            @(posedge clk); #1;
            cyc++;
        end
        ref_div(a2, b2, eq, er, ez);
        check("b2b second done_cycle", cyc, W + 1);
        check("b2b second quotient", quotient, eq);
        check("b2b second remainder", remainder, er);
        check("b2b second div_by_zero", div_by_zero, ez);
        last_q = eq; last_r = er; last_z = ez;
        repeat (2) @(posedge clk);

        // Random operands.
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
        end

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b, 0);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
